// File: rtl/fila_pkg.sv
// -----------------------------------------------------------------------------
// fila_pkg
// Shared definitions for the fila_param queue: default geometry and the
// operation encoding decoded from the effective enqueue/dequeue commands.
// -----------------------------------------------------------------------------
package fila_pkg;

  localparam int FILA_WIDTH = 8;
  localparam int FILA_DEPTH = 8;

  // Operation selected for the current cycle once clear has been ruled out.
  typedef enum logic [1:0] {
    OP_NONE,
    OP_ENQ,
    OP_DEQ,
    OP_BOTH
  } fila_op_t;

endpackage

// File: rtl/detector_borda.sv
// -----------------------------------------------------------------------------
// detector_borda
// 1-bit rising-edge detector. The previous sample resets to 0, so an input
// that is already high when reset releases is reported as an edge.
//
// Ports:
//   clk    : clock, rising edge
//   rst    : asynchronous active-high reset
//   sig_i  : level input
//   rise_o : high while sig_i is high and the previous sample was low
// -----------------------------------------------------------------------------
module detector_borda (
  input  logic clk,
  input  logic rst,
  input  logic sig_i,
  output logic rise_o
);

  logic prev_q;

  // NOTE: sequential state is always written with non-blocking assignments so
  // every register sees the pre-edge value of every other register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= sig_i;
    end
  end

  assign rise_o = sig_i & ~prev_q;

endmodule

// File: rtl/fila_param.sv
// -----------------------------------------------------------------------------
// fila_param
// FIFO of DEPTH entries x WIDTH bits with the whole contents exposed, oldest
// entry in slot 0. Commands are edge- or level-triggered (EDGE_MODE), clear
// is a synchronous level-sensitive flush, and overflow/underflow are sticky.
//
// Ports:
//   clk_10KHz     : clock, all state updates on the rising edge
//   reset         : asynchronous active-high reset, clears all state
//   data_in       : element to enqueue
//   enqueue_in    : enqueue command
//   dequeue_in    : dequeue command
//   clear_in      : synchronous flush, wins over enqueue/dequeue
//   data_out      : last dequeued element (registered)
//   len_out       : occupancy, 0..DEPTH
//   vector_out    : queue slots, slot 0 = oldest; slots >= len_out read 0
//   full_out      : len_out == DEPTH
//   empty_out     : len_out == 0
//   overflow_out  : sticky, an enqueue was dropped on a full queue
//   underflow_out : sticky, a dequeue was rejected on an empty queue
// -----------------------------------------------------------------------------
module fila_param
  import fila_pkg::*;
#(
  parameter  int WIDTH     = FILA_WIDTH,
  parameter  int DEPTH     = FILA_DEPTH,
  parameter  bit EDGE_MODE = 1'b1,
  localparam int LW        = $clog2(DEPTH + 1)
) (
  input  logic             clk_10KHz,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             enqueue_in,
  input  logic             dequeue_in,
  input  logic             clear_in,
  output logic [WIDTH-1:0] data_out,
  output logic [LW-1:0]    len_out,
  output logic [WIDTH-1:0] vector_out [DEPTH-1:0],
  output logic             full_out,
  output logic             empty_out,
  output logic             overflow_out,
  output logic             underflow_out
);

  logic             enq;
  logic             deq;
  fila_op_t         op;

  logic [WIDTH-1:0] slots_q   [DEPTH-1:0];
  logic [WIDTH-1:0] slots_shf [DEPTH-1:0];
  logic [LW-1:0]    len_q;
  logic [WIDTH-1:0] data_q;
  logic             ovf_q;
  logic             udf_q;
  logic             full;
  logic             empty;

  // ---------------------------------------------------------------------------
  // Effective commands: edge-detected or raw level.
  // ---------------------------------------------------------------------------
  generate
    if (EDGE_MODE) begin : g_edge
      detector_borda u_det_enq (
        .clk    (clk_10KHz),
        .rst    (reset),
        .sig_i  (enqueue_in),
        .rise_o (enq)
      );
      detector_borda u_det_deq (
        .clk    (clk_10KHz),
        .rst    (reset),
        .sig_i  (dequeue_in),
        .rise_o (deq)
      );
    end else begin : g_level
      assign enq = enqueue_in;
      assign deq = dequeue_in;
    end
  endgenerate

  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    op = OP_NONE;
    unique case ({enq, deq})
      2'b10:   op = OP_ENQ;
      2'b01:   op = OP_DEQ;
      2'b11:   op = OP_BOTH;
      default: op = OP_NONE;
    endcase
  end

  // Contents after removing the head. Because slots at or beyond len are
  // already zero, shifting in a zero at the top keeps that invariant.
  always_comb begin
    for (int i = 0; i < DEPTH - 1; i++) begin
      slots_shf[i] = slots_q[i+1];
    end
    slots_shf[DEPTH-1] = '0;
  end

  assign full  = (len_q == LW'(DEPTH));
  assign empty = (len_q == '0);

  // ---------------------------------------------------------------------------
  // Queue state.
  // ---------------------------------------------------------------------------
  // NOTE: the slot storage is reset along with the control state because the
  // contents are visible on vector_out and must read zero out of reset.
  always_ff @(posedge clk_10KHz or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        slots_q[i] <= '0;
      end
      len_q  <= '0;
      data_q <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else if (clear_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        slots_q[i] <= '0;
      end
      len_q  <= '0;
      data_q <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      unique case (op)
        OP_NONE: begin
        end

        OP_ENQ: begin
          if (full) begin
            ovf_q <= 1'b1;
          end else begin
            for (int i = 0; i < DEPTH; i++) begin
              if (LW'(i) == len_q) slots_q[i] <= data_in;
            end
            len_q <= len_q + LW'(1);
          end
        end

        OP_DEQ: begin
          if (empty) begin
            udf_q <= 1'b1;
          end else begin
            data_q  <= slots_q[0];
            slots_q <= slots_shf;
            len_q   <= len_q - LW'(1);
          end
        end

        OP_BOTH: begin
          if (empty) begin
            // Enqueue lands in slot 0; the dequeue had nothing to take.
            slots_q[0] <= data_in;
            len_q      <= LW'(1);
            udf_q      <= 1'b1;
          end else begin
            // Head leaves, new element takes the top occupied slot after the
            // shift; occupancy is unchanged.
            data_q <= slots_q[0];
            for (int i = 0; i < DEPTH; i++) begin
              if (LW'(i + 1) == len_q) slots_q[i] <= data_in;
              else                     slots_q[i] <= slots_shf[i];
            end
          end
        end

        default: begin
        end
      endcase
    end
  end

  assign data_out      = data_q;
  assign len_out       = len_q;
  assign vector_out    = slots_q;
  assign full_out      = full;
  assign empty_out     = empty;
  assign overflow_out  = ovf_q;
  assign underflow_out = udf_q;

endmodule

// File: tb/tb_fila_param.sv
// -----------------------------------------------------------------------------
// tb_fila_param
// Directed bench for fila_param: 8x8 edge mode (A), 8x8 level mode (B) and
// 16x3 edge mode (C), all on one clock and one reset.
// -----------------------------------------------------------------------------
module tb_fila_param;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  // Instance A: WIDTH=8, DEPTH=8, edge mode
  logic [7:0]  data_a;
  logic        enq_a, deq_a, clr_a;
  logic [7:0]  dout_a;
  logic [3:0]  len_a;
  logic [7:0]  vec_a [7:0];
  logic        full_a, empty_a, ovf_a, udf_a;

  // Instance B: WIDTH=8, DEPTH=8, level mode
  logic [7:0]  data_b;
  logic        enq_b, deq_b, clr_b;
  logic [7:0]  dout_b;
  logic [3:0]  len_b;
  logic [7:0]  vec_b [7:0];
  logic        full_b, empty_b, ovf_b, udf_b;

  // Instance C: WIDTH=16, DEPTH=3, edge mode
  logic [15:0] data_c;
  logic        enq_c, deq_c, clr_c;
  logic [15:0] dout_c;
  logic [1:0]  len_c;
  logic [15:0] vec_c [2:0];
  logic        full_c, empty_c, ovf_c, udf_c;

  fila_param #(.WIDTH(8), .DEPTH(8), .EDGE_MODE(1'b1)) u_a (
    .clk_10KHz(clk), .reset(reset), .data_in(data_a), .enqueue_in(enq_a),
    .dequeue_in(deq_a), .clear_in(clr_a), .data_out(dout_a), .len_out(len_a),
    .vector_out(vec_a), .full_out(full_a), .empty_out(empty_a),
    .overflow_out(ovf_a), .underflow_out(udf_a)
  );

  fila_param #(.WIDTH(8), .DEPTH(8), .EDGE_MODE(1'b0)) u_b (
    .clk_10KHz(clk), .reset(reset), .data_in(data_b), .enqueue_in(enq_b),
    .dequeue_in(deq_b), .clear_in(clr_b), .data_out(dout_b), .len_out(len_b),
    .vector_out(vec_b), .full_out(full_b), .empty_out(empty_b),
    .overflow_out(ovf_b), .underflow_out(udf_b)
  );

  fila_param #(.WIDTH(16), .DEPTH(3), .EDGE_MODE(1'b1)) u_c (
    .clk_10KHz(clk), .reset(reset), .data_in(data_c), .enqueue_in(enq_c),
    .dequeue_in(deq_c), .clear_in(clr_c), .data_out(dout_c), .len_out(len_c),
    .vector_out(vec_c), .full_out(full_c), .empty_out(empty_c),
    .overflow_out(ovf_c), .underflow_out(udf_c)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One command edge on A followed by a low cycle so the next one is an edge.
  task automatic pulse_a(input logic e, input logic d, input logic [7:0] v);
    data_a = v;
    enq_a  = e;
    deq_a  = d;
    tick();
    enq_a  = 1'b0;
    deq_a  = 1'b0;
    tick();
  endtask

  task automatic pulse_c(input logic e, input logic d, input logic [15:0] v);
    data_c = v;
    enq_c  = e;
    deq_c  = d;
    tick();
    enq_c  = 1'b0;
    deq_c  = 1'b0;
    tick();
  endtask

  task automatic clear_pulse_a();
    clr_a = 1'b1;
    tick();
    clr_a = 1'b0;
  endtask

  task automatic check_a_empty_slots(input string tag);
    for (int i = 0; i < 8; i++) check($sformatf("%s_slot%0d", tag, i), 32'(vec_a[i]), 32'h0);
  endtask

  logic [15:0] c_vals [3];

  initial begin
    c_vals[0] = 16'hBEEF;
    c_vals[1] = 16'h1234;
    c_vals[2] = 16'hCAFE;

    reset  = 1'b1;
    data_a = '0; enq_a = 1'b0; deq_a = 1'b0; clr_a = 1'b0;
    data_b = '0; enq_b = 1'b0; deq_b = 1'b0; clr_b = 1'b0;
    data_c = '0; enq_c = 1'b0; deq_c = 1'b0; clr_c = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    tick();

    // ---- reset state ----
    check("rst_len_a",   32'(len_a),   32'd0);
    check("rst_empty_a", 32'(empty_a), 32'd1);
    check("rst_full_a",  32'(full_a),  32'd0);
    check("rst_ovf_a",   32'(ovf_a),   32'd0);
    check("rst_udf_a",   32'(udf_a),   32'd0);
    check("rst_dout_a",  32'(dout_a),  32'd0);
    check_a_empty_slots("rst");
    check("rst_len_c",   32'(len_c),   32'd0);
    check("rst_empty_c", 32'(empty_c), 32'd1);

    // ---- fill and overflow: 0x11..0x99 ----
    for (int k = 1; k <= 9; k++) pulse_a(1'b1, 1'b0, 8'(k * 17));
    for (int i = 0; i < 8; i++) check($sformatf("fill_slot%0d", i), 32'(vec_a[i]), 32'((i + 1) * 17));
    check("fill_len",   32'(len_a),   32'd8);
    check("fill_full",  32'(full_a),  32'd1);
    check("fill_empty", 32'(empty_a), 32'd0);
    check("fill_ovf",   32'(ovf_a),   32'd1);
    check("fill_udf",   32'(udf_a),   32'd0);

    // ---- drain and underflow ----
    for (int k = 1; k <= 8; k++) begin
      pulse_a(1'b0, 1'b1, 8'h00);
      check($sformatf("drain_dout%0d", k), 32'(dout_a), 32'(k * 17));
      check($sformatf("drain_len%0d", k),  32'(len_a),  32'(8 - k));
    end
    pulse_a(1'b0, 1'b1, 8'h00);
    check("udf_dout",  32'(dout_a),  32'h88);
    check("udf_len",   32'(len_a),   32'd0);
    check("udf_empty", 32'(empty_a), 32'd1);
    check("udf_flag",  32'(udf_a),   32'd1);
    check("udf_ovf_sticky", 32'(ovf_a), 32'd1);
    check_a_empty_slots("drain");

    // ---- clear removes sticky flags ----
    clear_pulse_a();
    check("clr1_ovf",  32'(ovf_a),  32'd0);
    check("clr1_udf",  32'(udf_a),  32'd0);
    check("clr1_dout", 32'(dout_a), 32'd0);
    tick();

    // ---- simultaneous enqueue/dequeue on a full queue ----
    for (int k = 1; k <= 8; k++) pulse_a(1'b1, 1'b0, 8'(k * 17));
    pulse_a(1'b1, 1'b1, 8'hAA);
    check("both_full_dout", 32'(dout_a), 32'h11);
    for (int i = 0; i < 7; i++) check($sformatf("both_full_slot%0d", i), 32'(vec_a[i]), 32'((i + 2) * 17));
    check("both_full_slot7", 32'(vec_a[7]), 32'hAA);
    check("both_full_len",   32'(len_a),    32'd8);
    check("both_full_ovf",   32'(ovf_a),    32'd0);
    check("both_full_udf",   32'(udf_a),    32'd0);

    // ---- simultaneous enqueue/dequeue on an empty queue ----
    for (int k = 1; k <= 8; k++) pulse_a(1'b0, 1'b1, 8'h00);
    check("redrain_dout",  32'(dout_a),  32'hAA);
    check("redrain_empty", 32'(empty_a), 32'd1);
    pulse_a(1'b1, 1'b1, 8'h5C);
    check("both_empty_len",   32'(len_a),    32'd1);
    check("both_empty_slot0", 32'(vec_a[0]), 32'h5C);
    check("both_empty_slot1", 32'(vec_a[1]), 32'h00);
    check("both_empty_udf",   32'(udf_a),    32'd1);
    check("both_empty_dout",  32'(dout_a),   32'hAA);

    // ---- 4 entries with a flag set, then clear ----
    for (int k = 1; k <= 3; k++) pulse_a(1'b1, 1'b0, 8'(k));
    check("pre_clr_len",   32'(len_a),    32'd4);
    check("pre_clr_slot3", 32'(vec_a[3]), 32'h03);
    clear_pulse_a();
    check("clr2_len",   32'(len_a),   32'd0);
    check("clr2_empty", 32'(empty_a), 32'd1);
    check("clr2_udf",   32'(udf_a),   32'd0);
    check("clr2_dout",  32'(dout_a),  32'd0);
    check_a_empty_slots("clr2");
    tick();

    // ---- edge vs level: command held high for 3 cycles ----
    data_a = 8'h3C; enq_a = 1'b1;
    data_b = 8'h3C; enq_b = 1'b1;
    repeat (3) tick();
    enq_a = 1'b0;
    enq_b = 1'b0;
    tick();
    check("edge_len_a",   32'(len_a),    32'd1);
    check("edge_slot0_a", 32'(vec_a[0]), 32'h3C);
    check("edge_slot1_a", 32'(vec_a[1]), 32'h00);
    check("level_len_b",  32'(len_b),    32'd3);
    for (int i = 0; i < 3; i++) check($sformatf("level_slot%0d_b", i), 32'(vec_b[i]), 32'h3C);
    check("level_slot3_b", 32'(vec_b[3]), 32'h00);

    // ---- async reset between clock edges ----
    pulse_a(1'b1, 1'b0, 8'h44);
    check("pre_rst_len", 32'(len_a), 32'd2);
    #2;
    reset = 1'b1;
    #1;
    check("async_len",   32'(len_a),    32'd0);
    check("async_slot0", 32'(vec_a[0]), 32'h00);
    check("async_slot1", 32'(vec_a[1]), 32'h00);
    check("async_empty", 32'(empty_a),  32'd1);
    check("async_len_b", 32'(len_b),    32'd0);
    #1;
    reset  = 1'b0;
    data_a = 8'h77;
    enq_a  = 1'b1;
    tick();
    enq_a  = 1'b0;
    check("post_rst_slot0", 32'(vec_a[0]), 32'h77);
    check("post_rst_len",   32'(len_a),    32'd1);
    tick();

    // ---- WIDTH=16, DEPTH=3 sweep ----
    for (int k = 0; k < 3; k++) begin
      pulse_c(1'b1, 1'b0, c_vals[k]);
      check($sformatf("c_fill_len%0d", k), 32'(len_c), 32'(k + 1));
    end
    check("c_full", 32'(full_c), 32'd1);
    pulse_c(1'b1, 1'b0, 16'h5555);
    check("c_ovf", 32'(ovf_c), 32'd1);
    check("c_ovf_len", 32'(len_c), 32'd3);
    for (int i = 0; i < 3; i++) check($sformatf("c_slot%0d", i), 32'(vec_c[i]), 32'(c_vals[i]));
    for (int k = 0; k < 3; k++) begin
      pulse_c(1'b0, 1'b1, 16'h0000);
      check($sformatf("c_drain_dout%0d", k), 32'(dout_c), 32'(c_vals[k]));
      check($sformatf("c_drain_len%0d", k),  32'(len_c),  32'(2 - k));
    end
    pulse_c(1'b0, 1'b1, 16'h0000);
    check("c_udf",       32'(udf_c),   32'd1);
    check("c_udf_dout",  32'(dout_c),  32'hCAFE);
    check("c_udf_empty", 32'(empty_c), 32'd1);
    check("c_udf_slot2", 32'(vec_c[2]), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
